// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the multiply/divide sequencer: operation and FSM
// state encodings, the iteration count, and small op-decoding helpers.
package muldiv_seq_pkg;

    localparam int MD_ITER_CNT = 32;

    typedef enum logic [1:0] {
        MD_MULT  = 2'b00,
        MD_MULTU = 2'b01,
        MD_DIV   = 2'b10,
        MD_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [2:0] {
        MD_IDLE = 3'd0,
        MD_PREP = 3'd1,
        MD_ITER = 3'd2,
        MD_FIX  = 3'd3,
        MD_DONE = 3'd4
    } md_state_e;

    function automatic logic md_is_div(input md_op_e op);
        return op[1];
    endfunction

    function automatic logic md_is_signed(input md_op_e op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Decode-side bundle for the multiply/divide sequencer: launch, HI/LO move
// writes, HI/LO read-back and the stall/completion handshake.
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_ITER_CNT
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, mthi, mtlo, wdata,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, a, b, mthi, mtlo, wdata,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/muldiv_seq_step.sv
// One iteration of the shared 64-bit shift datapath.
// Multiply: shift-add, acc[0] selects whether the multiplicand is added into
// the upper half before the right shift; the 33-bit sum keeps the carry.
// Divide: restoring step; the remainder:quotient pair shifts left, the
// divisor is trial-subtracted from the upper half and the quotient bit is
// returned separately (nacc[0] is left zero).
module muldiv_seq_step
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_ITER_CNT
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   mag,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] nacc,
    output logic               qbit
);
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] rem_sub;

    // Compute both step flavours and select by mode.
    always_comb begin
        sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mag : {WIDTH{1'b0}})};
        rem     = acc[2*WIDTH-1:WIDTH-1];
        // The remainder after a successful subtract is below the divisor, so
        // the low WIDTH bits of the modular difference are exact.
        rem_sub = rem[WIDTH-1:0] - mag;
        qbit    = 1'b0;
        nacc    = {sum, acc[WIDTH-1:1]};
        if (is_div) begin
            qbit = (rem >= {1'b0, mag});
            nacc = {(qbit ? rem_sub : rem[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning HI/LO.
// IDLE -start-> PREP -> ITER (WIDTH steps) -> FIX -> DONE -> IDLE.
// Optional build macro MULDIV_FAST_MUL_EN: MULT/MULTU complete in one cycle
// through a `*` product and go straight to DONE without raising busy.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = MD_ITER_CNT
) (
    input  logic        clk,
    input  logic        rstn,
    muldiv_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH);

    md_state_e          state, state_nx;
    md_op_e             op_q;
    logic [WIDTH-1:0]   a_q, b_q, mag_b;
    logic [2*WIDTH-1:0] acc, step_acc;
    logic               step_q;
    logic [CW-1:0]      cnt;
    logic               sa, sb, dz;
    logic [WIDTH-1:0]   hi_q, lo_q, res_hi, res_lo;
    logic               busy, accept, fast_go;

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? -x : x;
    endfunction

    assign busy   = (state == MD_PREP) || (state == MD_ITER) || (state == MD_FIX);
    assign accept = bus.start && !busy;

`ifdef MULDIV_FAST_MUL_EN
    logic               fast_sgn;
    logic [2*WIDTH-1:0] fast_a, fast_b, fast_prod;

    assign fast_go   = accept && !md_is_div(md_op_e'(bus.op));
    assign fast_sgn  = md_is_signed(md_op_e'(bus.op));
    assign fast_a    = {{WIDTH{fast_sgn & bus.a[WIDTH-1]}}, bus.a};
    assign fast_b    = {{WIDTH{fast_sgn & bus.b[WIDTH-1]}}, bus.b};
    assign fast_prod = fast_a * fast_b;
`else
    assign fast_go = 1'b0;
`endif

    muldiv_seq_step #(.WIDTH(WIDTH)) u_step (
        .acc    (acc),
        .mag    (mag_b),
        .is_div (md_is_div(op_q)),
        .nacc   (step_acc),
        .qbit   (step_q)
    );

    // State register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= MD_IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; DONE accepts a new start just like IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            MD_IDLE, MD_DONE: state_nx = accept ? (fast_go ? MD_DONE : MD_PREP) : MD_IDLE;
            MD_PREP:          state_nx = MD_ITER;
            MD_ITER:          state_nx = (cnt == '0) ? MD_FIX : MD_ITER;
            MD_FIX:           state_nx = MD_DONE;
            default:          state_nx = MD_IDLE;
        endcase
    end

    // Operand capture, sign/magnitude preparation and the iteration loop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q  <= MD_MULT;
            a_q   <= '0;
            b_q   <= '0;
            mag_b <= '0;
            acc   <= '0;
            cnt   <= '0;
            sa    <= 1'b0;
            sb    <= 1'b0;
            dz    <= 1'b0;
        end else begin
            case (state)
                MD_IDLE, MD_DONE: begin
                    if (accept) begin
                        op_q <= md_op_e'(bus.op);
                        a_q  <= bus.a;
                        b_q  <= bus.b;
                        dz   <= 1'b0;
                    end
                end
                MD_PREP: begin
                    sa    <= md_is_signed(op_q) & a_q[WIDTH-1];
                    sb    <= md_is_signed(op_q) & b_q[WIDTH-1];
                    acc   <= {{WIDTH{1'b0}}, magnitude(a_q, md_is_signed(op_q) & a_q[WIDTH-1])};
                    mag_b <= magnitude(b_q, md_is_signed(op_q) & b_q[WIDTH-1]);
                    cnt   <= CW'(WIDTH - 1);
                    dz    <= md_is_div(op_q) && (b_q == '0);
                end
                MD_ITER: begin
                    acc <= step_acc | {{(2*WIDTH-1){1'b0}}, step_q};
                    cnt <= cnt - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sign correction of the unsigned magnitude result; unsigned ops pass through.
    always_comb begin
        res_hi = acc[2*WIDTH-1:WIDTH];
        res_lo = acc[WIDTH-1:0];
        if (md_is_div(op_q)) begin
            if (sa ^ sb) res_lo = -acc[WIDTH-1:0];
            if (sa)      res_hi = -acc[2*WIDTH-1:WIDTH];
        end else if (sa ^ sb) begin
            {res_hi, res_lo} = -acc;
        end
    end

    // HI/LO: moves only while idle; a completing result overrides a move.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else begin
            if (!busy && bus.mthi) hi_q <= bus.wdata;
            if (!busy && bus.mtlo) lo_q <= bus.wdata;
            if (state == MD_FIX && !dz) begin
                hi_q <= res_hi;
                lo_q <= res_lo;
            end
`ifdef MULDIV_FAST_MUL_EN
            if (fast_go) {hi_q, lo_q} <= fast_prod;
`endif
        end
    end

    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;
    assign bus.busy        = busy;
    assign bus.done        = (state == MD_DONE);
    assign bus.div_by_zero = (state == MD_DONE) && dz;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed cases plus randomized operations
// checked against an arithmetic reference model. Honours MULDIV_FAST_MUL_EN.
`timescale 1ns/1ps
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    localparam int W = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    exp_t mon_e;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    muldiv_seq_if #(.WIDTH(W)) bus();

    muldiv_seq #(.WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5ms;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse pops one expected result.
    initial begin
        forever begin
            @(negedge clk);
            if (rstn && bus.done) begin
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result_hi", bus.hi, mon_e.hi);
                    check("result_lo", bus.lo, mon_e.lo);
                    check("div_by_zero", bus.div_by_zero, mon_e.dz);
                    check("done_cycle", cyc, mon_e.cyc);
                    check("busy_at_done", bus.busy, 0);
                end
            end else if (rstn && bus.div_by_zero) begin
                check("dz_without_done", bus.div_by_zero, 0);
            end
        end
    end

    // Launch an op at the current negedge; the model result is queued.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sp, sq, sr;
        logic [63:0] p;
        int          lat;
        e.dz = 1'b0;
        lat  = 35;
        case (op)
            MD_MULT: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                p  = sp;
                m_hi = p[63:32];
                m_lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
                lat = 1;
`endif
            end
            MD_MULTU: begin
                p = {32'b0, a} * {32'b0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
`ifdef MULDIV_FAST_MUL_EN
                lat = 1;
`endif
            end
            MD_DIV: begin
                if (b == 0) e.dz = 1'b1;
                else begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    m_lo = sq[31:0];
                    m_hi = sr[31:0];
                end
            end
            default: begin
                if (b == 0) e.dz = 1'b1;
                else begin
                    m_lo = a / b;
                    m_hi = a % b;
                end
            end
        endcase
        e.hi  = m_hi;
        e.lo  = m_lo;
        e.cyc = cyc + lat;
        sbq.push_back(e);
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic mt(input logic hi_en, input logic lo_en, input logic [31:0] d);
        bus.mthi  = hi_en;
        bus.mtlo  = lo_en;
        bus.wdata = d;
        if (hi_en) m_hi = d;
        if (lo_en) m_lo = d;
        @(negedge clk);
        bus.mthi = 1'b0;
        bus.mtlo = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!bus.done && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (!bus.done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_done: got no done expected done within 60 cycles (cycle %0d)", cyc);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 9))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 15);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        bus.wdata = '0;

        repeat (2) @(negedge clk);
        check("reset_hi", bus.hi, 0);
        check("reset_lo", bus.lo, 0);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_dz", bus.div_by_zero, 0);
        rstn = 1'b1;
        @(negedge clk);

        // HI/LO moves, both together then individually.
        mt(1'b1, 1'b1, 32'h5A);
        check("mt_both_hi", bus.hi, 32'h5A);
        check("mt_both_lo", bus.lo, 32'h5A);
        mt(1'b1, 1'b0, 32'h11);
        mt(1'b0, 1'b1, 32'h22);
        check("mt_hi", bus.hi, 32'h11);
        check("mt_lo", bus.lo, 32'h22);

        // Divide by zero keeps HI/LO.
        issue(MD_DIV, 32'd5, 32'd0);
        wait_done();

        // Directed arithmetic, each follow-on started in the DONE cycle.
        issue(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done();
        issue(MD_MULTU, 32'hFFFF_FFFF, 32'd2);
        wait_done();
        issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done();
        issue(MD_DIVU, 32'd100, 32'd7);
        wait_done();
        issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done();
        check("wrap_div_lo", m_lo, 32'h8000_0000);

        // Start and mthi while busy are both dropped.
        @(negedge clk);
        issue(MD_DIVU, 32'd100, 32'd7);
        check("busy_after_start", bus.busy, 1);
        repeat (4) @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MD_MULTU;
        bus.a     = 32'd9;
        bus.b     = 32'd9;
        bus.mthi  = 1'b1;
        bus.wdata = 32'hAB;
        @(negedge clk);
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        wait_done();
        repeat (40) @(negedge clk);
        check("busy_drop_hi", bus.hi, 32'd2);
        check("busy_drop_queue", sbq.size(), 0);

        // Reset in the middle of the iteration loop.
        issue(MD_DIVU, 32'h1234, 32'd3);
        repeat (9) @(negedge clk);
        rstn = 1'b0;
        #1;
        check("abort_hi", bus.hi, 0);
        check("abort_lo", bus.lo, 0);
        check("abort_busy", bus.busy, 0);
        sbq.delete();
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        rstn = 1'b1;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) nd++;
        end
        check("abort_no_done", nd, 0);

`ifdef MULDIV_FAST_MUL_EN
        issue(MD_MULT, 32'd6, 32'd7);
        check("fast_busy", bus.busy, 0);
        check("fast_done", bus.done, 1);
        check("fast_lo", bus.lo, 32'd42);
        check("fast_hi", bus.hi, 32'd0);
`endif

        // Randomized operations with occasional moves and idle gaps.
        for (int i = 0; i < 1000; i++) begin
            case ($urandom_range(0, 3))
                0: begin
                    @(negedge clk);
                    mt(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
                end
                1: @(negedge clk);
                default: ;
            endcase
            issue(2'($urandom_range(0, 3)), rnd_val(), rnd_val());
            wait_done();
        end

        repeat (5) @(negedge clk);
        check("final_queue", sbq.size(), 0);
        check("final_hi", bus.hi, m_hi);
        check("final_lo", bus.lo, m_lo);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
